// File: rtl/main_src_pkg.sv
// Shared definitions for the main_src sequencing front-end.
// Holds default geometry, the chunk-vector width and the driver FSM state type.
package main_src_pkg;

  localparam int unsigned DefBitLength = 16;
  localparam int unsigned DefHidLength = 24;
  localparam int unsigned DefDataN     = 6;
  localparam int unsigned DefNumChunk  = 3;
  localparam int unsigned DefTimeout   = 1024;

  // Width of one chunk vector presented on main_src.data_in.
  localparam int unsigned ChunkWidth = 4 * DefBitLength * DefDataN;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } drv_state_e;

endpackage

// File: rtl/hid_serializer.sv
// Parallel-load, serial-out buffer for the hidden vector returned by main_src.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   load_i         capture data_i and start presenting element 0
//   data_i         HidLength elements of BitLength bits, element 0 in the LSBs
//   valid_o/ready_i/data_o/last_o  downstream handshake, last_o on the final element
module hid_serializer #(
  parameter int unsigned BitLength = 16,
  parameter int unsigned HidLength = 24
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           load_i,
  input  logic [HidLength*BitLength-1:0] data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [BitLength-1:0]           data_o,
  output logic                           last_o
);

  localparam int unsigned VecW = HidLength * BitLength;
  localparam int unsigned IdxW = (HidLength > 1) ? $clog2(HidLength) : 1;

  logic [VecW-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i) begin
      shreg_d = data_i;
      idx_d   = '0;
      valid_d = 1'b1;
      last_d  = (HidLength == 1);
    end else if (valid_q && ready_i) begin
      // Element 0 always sits in the LSBs; shift the next one down.
      shreg_d = {{BitLength{1'b0}}, shreg_q[VecW-1:BitLength]};
      idx_d   = idx_q + 1'b1;
      valid_d = !last_q;
      last_d  = !last_q && (idx_q == IdxW'(HidLength - 2));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = shreg_q[BitLength-1:0];
  assign last_o  = last_q;

endmodule

// File: rtl/main_src_driver.sv
// Sequencing front-end for main_src: packs input words into chunk vectors, runs
// main_src once per chunk via run/selecter/valid, and streams the final hidden
// vector out word by word.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready/in_data     upstream word stream
//   ms_run/ms_selecter/ms_data_in control and chunk data to main_src
//   ms_valid/ms_data_out          completion and result from main_src
//   out_valid/out_ready/out_data/out_last  result word stream
//   busy                          not idle at the start of a frame
//   err                           one-cycle pulse when main_src times out
module main_src_driver
  import main_src_pkg::*;
#(
  parameter int unsigned BIT_LENGTH = DefBitLength,
  parameter int unsigned HID_LENGTH = DefHidLength,
  parameter int unsigned DATA_N     = DefDataN,
  parameter int unsigned NUM_CHUNK  = DefNumChunk,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BIT_LENGTH-1:0]            in_data,
  output logic                             ms_run,
  output logic [1:0]                       ms_selecter,
  output logic [4*BIT_LENGTH*DATA_N-1:0]   ms_data_in,
  input  logic                             ms_valid,
  input  logic [HID_LENGTH*BIT_LENGTH-1:0] ms_data_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BIT_LENGTH-1:0]            out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic                             err
);

  localparam int unsigned Words  = 4 * DATA_N;
  localparam int unsigned ChunkW = BIT_LENGTH * Words;
  localparam int unsigned WordW  = $clog2(Words);
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  drv_state_e        state_q, state_d;
  logic [1:0]        chunk_q, chunk_d;
  logic [WordW-1:0]  wcnt_q, wcnt_d;
  logic [ChunkW-1:0] data_q, data_d;
  logic [TimerW-1:0] tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic              ms_run_q, in_ready_q, busy_q, busy_d;
  logic              load_res;
  logic              ser_valid, ser_last;

  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    wcnt_d   = wcnt_q;
    data_d   = data_q;
    tcnt_d   = tcnt_q;
    err_d    = 1'b0;
    load_res = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_valid && in_ready_q) begin
          data_d[BIT_LENGTH*wcnt_q +: BIT_LENGTH] = in_data;
          if (wcnt_q == WordW'(Words - 1)) begin
            wcnt_d  = '0;
            tcnt_d  = '0;
            state_d = StRun;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        // ms_valid is checked first so it wins over a same-edge timeout.
        if (ms_valid) begin
          if (chunk_q != 2'(NUM_CHUNK - 1)) begin
            chunk_d = chunk_q + 2'd1;
            state_d = StLoad;
          end else begin
            chunk_d  = '0;
            load_res = 1'b1;
            state_d  = StDrain;
          end
        end else if (tcnt_q == TimerW'(TIMEOUT - 1)) begin
          // Abandon the partial frame and start over from chunk 0.
          err_d   = 1'b1;
          chunk_d = '0;
          wcnt_d  = '0;
          state_d = StLoad;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (ser_valid && out_ready && ser_last) begin
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
    busy_d = !((state_d == StLoad) && (chunk_d == '0) && (wcnt_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      chunk_q    <= '0;
      wcnt_q     <= '0;
      data_q     <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      ms_run_q   <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chunk_q    <= chunk_d;
      wcnt_q     <= wcnt_d;
      data_q     <= data_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      // Registered decodes of the next state keep every output flop-driven.
      ms_run_q   <= (state_d == StRun);
      in_ready_q <= (state_d == StLoad);
      busy_q     <= busy_d;
    end
  end

  hid_serializer #(
    .BitLength(BIT_LENGTH),
    .HidLength(HID_LENGTH)
  ) u_hid_serializer (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load_res),
    .data_i (ms_data_out),
    .valid_o(ser_valid),
    .ready_i(out_ready),
    .data_o (out_data),
    .last_o (ser_last)
  );

  assign in_ready    = in_ready_q;
  assign ms_run      = ms_run_q;
  assign ms_selecter = chunk_q;
  assign ms_data_in  = data_q;
  assign out_valid   = ser_valid;
  assign out_last    = ser_last;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_main_src_driver.sv
// Self-checking bench for main_src_driver with a behavioural main_src model.
module tb_main_src_driver;

  localparam int HL        = 24;
  localparam int NC        = 3;
  localparam int TO        = 1024;
  localparam int WORDS     = 24;
  localparam int MODEL_LAT = 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         ms_run;
  logic [1:0]   ms_selecter;
  logic [383:0] ms_data_in;
  logic         ms_valid;
  logic [383:0] ms_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  main_src_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ms_run     (ms_run),
    .ms_selecter(ms_selecter),
    .ms_data_in (ms_data_in),
    .ms_valid   (ms_valid),
    .ms_data_out(ms_data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural main_src: valid MODEL_LAT cycles after run rises, data_out[i] = base + i.
  logic [15:0] model_base;
  bit          model_hang;
  bit          spur_valid;
  int          mcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mcnt <= 0;
    else if (!ms_run) mcnt <= 0;
    else              mcnt <= mcnt + 1;
  end

  assign ms_valid = spur_valid | (!model_hang & ms_run & (mcnt == MODEL_LAT - 1));

  always_comb begin
    ms_data_out = '0;
    for (int i = 0; i < HL; i++) ms_data_out[16*i +: 16] = model_base + 16'(i);
  end

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    bit          bubbles;
    int          stall_at;
    int          stall_len;
    int          spur_at;
    logic [15:0] base;
    logic [15:0] exp_last;
  } frame_t;

  exp_t        sb_q[$];
  int          drv_chunk;
  int          cyc, rise_cyc, xfer_cnt, stall_at, stall_left, err_cnt;
  logic        prev_run;
  logic [15:0] last_seen;

  function automatic logic [383:0] chunk_vec(input int c);
    logic [383:0] v;
    for (int k = 0; k < WORDS; k++) v[16*k +: 16] = 16'(c * WORDS + k);
    return v;
  endfunction

  // Monitor: RUN/err timing, chunk presentation, scoreboard pop and out_ready pacing.
  initial begin
    exp_t e;
    prev_run  = 1'b0;
    out_ready = 1'b1;
    cyc       = 0;
    rise_cyc  = 0;
    err_cnt   = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_run  = 1'b0;
        out_ready = 1'b1;
      end else begin
        if (ms_run && !prev_run) rise_cyc = cyc;
        if (!ms_run && prev_run) begin
          if (!err) check("run_latency", cyc - rise_cyc, MODEL_LAT);
          check("post_run_state", in_ready | out_valid, 1);
        end
        if (err) begin
          err_cnt++;
          check("err_time", cyc - rise_cyc, TO);
          check("err_run_low", ms_run, 0);
        end
        if (ms_run) begin
          check("run_sel", ms_selecter, drv_chunk[1:0]);
          check("run_data", ms_data_in, chunk_vec(drv_chunk));
        end
        if (out_valid && stall_left > 0 && xfer_cnt == stall_at) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h with no output expected", out_data);
          end else if (out_ready) begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
            xfer_cnt++;
            if (out_last) last_seen = out_data;
          end else begin
            check("stall_hold", {out_last, out_data}, {sb_q[0].last, sb_q[0].data});
          end
        end
        prev_run = ms_run;
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    int n;
    n        = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_run_done(input int lim);
    int n;
    n = 0;
    while (ms_run && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("run_done", ms_run, 0);
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", sb_q.size(), 0);
  endtask

  task automatic push_expected(input logic [15:0] base);
    exp_t e;
    for (int i = 0; i < HL; i++) begin
      e.data = base + 16'(i);
      e.last = (i == HL - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic run_frame(input frame_t f);
    model_base = f.base;
    stall_at   = f.stall_at;
    stall_left = f.stall_len;
    xfer_cnt   = 0;
    last_seen  = '0;
    for (int c = 0; c < NC; c++) begin
      drv_chunk = c;
      for (int k = 0; k < WORDS; k++) begin
        if (c == 0 && k == f.spur_at) begin
          in_valid   = 1'b0;
          spur_valid = 1'b1;
          repeat (2) @(negedge clk);
          spur_valid = 1'b0;
          check("spur_ready", in_ready, 1);
          check("spur_run", ms_run, 0);
          check("spur_busy", busy, 1);
          check("spur_sel", ms_selecter, 0);
        end
        if (f.bubbles) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
        send_word(16'(c * WORDS + k));
        if (c == NC - 1 && k == WORDS - 1) push_expected(f.base);
      end
      check("run_start", ms_run, 1);
      wait_run_done(50);
    end
    wait_drain(600);
    check("frame_count", xfer_cnt, HL);
    check("frame_last", last_seen, f.exp_last);
  endtask

  frame_t rows[5];

  initial begin
    rows[0] = '{0, -1, 0, -1, 16'h0100, 16'h0117};
    rows[1] = '{1, 10, 3, -1, 16'h0100, 16'h0117};
    rows[2] = '{0,  0, 2, -1, 16'hA5F0, 16'hA607};
    rows[3] = '{1, 23, 4, -1, 16'hFFF0, 16'h0007};
    rows[4] = '{0, -1, 0, 10, 16'h1234, 16'h124B};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    model_base = 16'h0100;
    model_hang = 1'b0;
    spur_valid = 1'b0;
    drv_chunk  = 0;
    stall_at   = -1;
    stall_left = 0;
    xfer_cnt   = 0;
    last_seen  = '0;

    repeat (12) begin
      @(negedge clk);
      check("reset_ctl", {in_ready, ms_run, ms_selecter, out_valid, out_data, out_last, busy, err},
            0);
      check("reset_data", ms_data_in, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", in_ready, 1);
    check("release_busy", busy, 0);

    foreach (rows[i]) run_frame(rows[i]);

    // main_src never answers: expect one err pulse and a clean restart.
    model_hang = 1'b1;
    drv_chunk  = 0;
    for (int k = 0; k < WORDS; k++) send_word(16'(k));
    check("to_run", ms_run, 1);
    wait_run_done(TO + 50);
    @(negedge clk);
    check("to_err_once", err_cnt, 1);
    check("to_ready", in_ready, 1);
    check("to_busy", busy, 0);
    check("to_sel", ms_selecter, 0);
    model_hang = 1'b0;
    run_frame(rows[0]);

    // Reset while chunk 1 is running.
    drv_chunk = 0;
    for (int k = 0; k < WORDS; k++) send_word(16'(k));
    wait_run_done(50);
    drv_chunk = 1;
    for (int k = 0; k < WORDS; k++) send_word(16'(WORDS + k));
    check("mr_run", ms_run, 1);
    check("mr_sel_before", ms_selecter, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_run_low", ms_run, 0);
    check("mr_sel_low", ms_selecter, 0);
    check("mr_busy_low", busy, 0);
    check("mr_ready_low", in_ready, 0);
    check("mr_data_low", ms_data_in, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_release_ready", in_ready, 1);
    run_frame(rows[0]);

    check("err_total", err_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
